store_trace_fifo: RTL and testbench

Buffers every data-memory write issued by the single-cycle core (memwrite, word address, write data) and drains the captured stores in order through a valid/ready output port, feeding the board's 16-bit result display or a host logger. It sits downstream of the core's data-memory write port, in parallel with the data memory, and never stalls the core. When the buffer is full, stores are dropped and flagged.

---
 rtl/store_trace_pkg.sv | 22 ++
 rtl/trace_fifo_mem.sv | 36 +++
 rtl/store_trace_fifo.sv | 118 +++++++++++
 tb/tb_store_trace_fifo.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_trace_pkg.sv
// ============================================================================
//  Module : store_trace_pkg
//  Brief  : Shared types and constants for the store trace FIFO.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package store_trace_pkg;

   localparam int C_DEFAULT_DEPTH = 8;
   localparam int C_DEFAULT_AW    = 32;
   localparam int C_DEFAULT_DW    = 32;
   localparam int C_DROP_CNT_W    = 16;

   typedef struct packed {
      logic [C_DEFAULT_AW-1:0] addr;
      logic [C_DEFAULT_DW-1:0] data;
   } trace_entry_t;

endpackage

`default_nettype wire

// File: rtl/trace_fifo_mem.sv
// ============================================================================
//  Module : trace_fifo_mem
//  Brief  : DEPTH x WIDTH register array, one write port, async read port.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module trace_fifo_mem
   import store_trace_pkg::*;
#(
   parameter int DEPTH = C_DEFAULT_DEPTH,
   parameter int WIDTH = C_DEFAULT_AW + C_DEFAULT_DW,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   // Contents are don't-care after reset, so the array carries no reset.
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/store_trace_fifo.sv
// ============================================================================
//  Module : store_trace_fifo
//  Brief  : Captures core data-memory stores and drains them in order over a
//           first-word fall-through valid/ready port. Optional saturating
//           drop counter enabled by STORE_TRACE_DROPCNT_EN.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module store_trace_fifo
   import store_trace_pkg::*;
#(
   parameter int DEPTH = C_DEFAULT_DEPTH,
   parameter int AW    = C_DEFAULT_AW,
   parameter int DW    = C_DEFAULT_DW
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       memwrite,
   input  logic [AW-1:0]              addr,
   input  logic [DW-1:0]              wdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [AW-1:0]              out_addr,
   output logic [DW-1:0]              out_data,
   output logic [15:0]                out_result,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       drop
`ifdef STORE_TRACE_DROPCNT_EN
   ,
   output logic [C_DROP_CNT_W-1:0]    drop_cnt
`endif
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_lvl_w = c_ptr_w + 1;
   localparam int c_ent_w = AW + DW;

   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_lvl_w-1:0] r_level;
   logic               r_drop;

   logic               w_valid;
   logic               w_full;
   logic               w_pop;
   logic               w_accept;
   logic               w_discard;
   logic [c_ent_w-1:0] w_rd_entry;

   assign w_valid   = (r_level != '0);
   assign w_full    = (r_level == c_lvl_w'(DEPTH));
   assign w_pop     = w_valid & out_ready;
   // A full buffer still takes a store when the head leaves in the same cycle.
   assign w_accept  = memwrite & (~w_full | w_pop);
   assign w_discard = memwrite & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_drop   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({w_accept, w_pop})
            2'b10:   r_level <= r_level + c_lvl_w'(1);
            2'b01:   r_level <= r_level - c_lvl_w'(1);
            default: r_level <= r_level;
         endcase
         r_drop <= w_discard;
      end
   end

   trace_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (c_ent_w),
      .PTR_W (c_ptr_w)
   ) u_mem (
      .clk   (clk),
      .we    (w_accept),
      .waddr (r_wr_ptr),
      .wdata ({addr, wdata}),
      .raddr (r_rd_ptr),
      .rdata (w_rd_entry)
   );

   assign out_valid  = w_valid;
   assign out_addr   = w_rd_entry[c_ent_w-1:DW];
   assign out_data   = w_rd_entry[DW-1:0];
   assign out_result = w_rd_entry[15:0];
   assign level      = r_level;
   assign full       = w_full;
   assign drop       = r_drop;

`ifdef STORE_TRACE_DROPCNT_EN
   logic [C_DROP_CNT_W-1:0] r_drop_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_drop_cnt <= '0;
      end else if (w_discard && (r_drop_cnt != '1)) begin
         r_drop_cnt <= r_drop_cnt + C_DROP_CNT_W'(1);
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_trace_fifo.sv
// ============================================================================
//  Module : tb_store_trace_fifo
//  Brief  : Directed self-checking bench for store_trace_fifo.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_store_trace_fifo;
   import store_trace_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic [15:0] out_result;
   logic [3:0]  level;
   logic        full;
   logic        drop;
`ifdef STORE_TRACE_DROPCNT_EN
   logic [15:0] drop_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   store_trace_fifo #(.DEPTH(8), .AW(32), .DW(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .memwrite   (memwrite),
      .addr       (addr),
      .wdata      (wdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .out_result (out_result),
      .level      (level),
      .full       (full),
      .drop       (drop)
`ifdef STORE_TRACE_DROPCNT_EN
      ,
      .drop_cnt   (drop_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; memwrite = 1'b0; out_ready = 1'b0; addr = '0; wdata = '0;
      step(); step();
      reset = 1'b0;
      @(negedge clk);
      n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL rst_level got=%0d exp=0", level); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
      n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full got=%b exp=0", full); end
      n_vec++; if (drop !== 1'b0) begin n_err++; $display("FAIL rst_drop got=%b exp=0", drop); end
`ifdef STORE_TRACE_DROPCNT_EN
      n_vec++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL rst_dropcnt got=%0d exp=0", drop_cnt); end
`endif
   endtask

   task automatic test_fibonacci();
      int fib[8] = '{0, 1, 1, 2, 3, 5, 8, 13};
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         memwrite = 1'b1; addr = 32'(i + 2); wdata = 32'(fib[i]);
         step();
         @(negedge clk);
         n_vec++;
         if (out_valid !== 1'b1 || out_addr !== 32'(i + 2) || out_data !== 32'(fib[i])) begin
            n_err++;
            $display("FAIL fib_%0d got v=%b a=%0d d=%0d exp v=1 a=%0d d=%0d",
                     i, out_valid, out_addr, out_data, i + 2, fib[i]);
         end
         n_vec++; if (drop !== 1'b0) begin n_err++; $display("FAIL fib_drop_%0d got=%b exp=0", i, drop); end
      end
      memwrite = 1'b0;
      step();
      @(negedge clk);
      n_vec++; if (level !== 4'd0 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL fib_empty got level=%0d v=%b exp level=0 v=0", level, out_valid);
      end
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         memwrite = 1'b1; addr = 32'(i); wdata = 32'(100 + i);
         step();
         @(negedge clk);
         if (i == 7) begin
            n_vec++; if (level !== 4'd8 || full !== 1'b1) begin
               n_err++; $display("FAIL ovf_full got level=%0d full=%b exp level=8 full=1", level, full);
            end
         end
         n_vec++; if (drop !== (i >= 8)) begin
            n_err++; $display("FAIL ovf_drop_%0d got=%b exp=%b", i, drop, (i >= 8));
         end
      end
      memwrite = 1'b0;
      step();
      @(negedge clk);
      n_vec++; if (drop !== 1'b0 || level !== 4'd8) begin
         n_err++; $display("FAIL ovf_after got drop=%b level=%0d exp drop=0 level=8", drop, level);
      end
`ifdef STORE_TRACE_DROPCNT_EN
      n_vec++; if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL ovf_dropcnt got=%0d exp=2", drop_cnt); end
`endif
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         n_vec++; if (out_valid !== 1'b1 || out_data !== 32'(100 + k) || out_addr !== 32'(k)) begin
            n_err++; $display("FAIL ovf_drain_%0d got v=%b a=%0d d=%0d exp v=1 a=%0d d=%0d",
                              k, out_valid, out_addr, out_data, k, 100 + k);
         end
         step();
         @(negedge clk);
      end
      n_vec++; if (out_valid !== 1'b0 || level !== 4'd0) begin
         n_err++; $display("FAIL ovf_empty got v=%b level=%0d exp v=0 level=0", out_valid, level);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_full_push_pop();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         memwrite = 1'b1; addr = 32'(10 + i); wdata = 32'(200 + i);
         step();
      end
      memwrite = 1'b1; addr = 32'd20; wdata = 32'd55; out_ready = 1'b1;
      step();
      memwrite = 1'b0;
      @(negedge clk);
      n_vec++; if (level !== 4'd8 || full !== 1'b1) begin
         n_err++; $display("FAIL fpp_level got level=%0d full=%b exp level=8 full=1", level, full);
      end
      n_vec++; if (drop !== 1'b0) begin n_err++; $display("FAIL fpp_drop got=%b exp=0", drop); end
      for (int k = 0; k < 8; k++) begin
         logic [31:0] ea;
         logic [31:0] ed;
         ea = (k < 7) ? 32'(11 + k) : 32'd20;
         ed = (k < 7) ? 32'(201 + k) : 32'd55;
         n_vec++; if (out_valid !== 1'b1 || out_addr !== ea || out_data !== ed) begin
            n_err++; $display("FAIL fpp_drain_%0d got v=%b a=%0d d=%0d exp v=1 a=%0d d=%0d",
                              k, out_valid, out_addr, out_data, ea, ed);
         end
         step();
         @(negedge clk);
      end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fpp_empty got v=%b exp=0", out_valid); end
`ifdef STORE_TRACE_DROPCNT_EN
      n_vec++; if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL fpp_dropcnt got=%0d exp=2", drop_cnt); end
`endif
      out_ready = 1'b0;
   endtask

   task automatic test_wrap();
      trace_entry_t q[$];
      trace_entry_t e;
      int   pushes = 0;
      int   cyc    = 0;
      logic exp_drop = 1'b0;
      logic pop;
      logic acc;
      while ((pushes < 20 || q.size() != 0) && cyc < 200) begin
         memwrite  = (pushes < 20) && (cyc % 3 != 2);
         out_ready = (pushes >= 20) || (cyc % 2 == 1);
         addr      = 32'(500 + pushes);
         wdata     = 32'(32'h1000 + pushes);
         n_vec++; if (level !== 4'(q.size()) || level > 4'd8) begin
            n_err++; $display("FAIL wrap_level_c%0d got=%0d exp=%0d", cyc, level, q.size());
         end
         n_vec++; if (out_valid !== (q.size() != 0)) begin
            n_err++; $display("FAIL wrap_valid_c%0d got=%b exp=%b", cyc, out_valid, (q.size() != 0));
         end
         if (q.size() != 0) begin
            n_vec++; if (out_addr !== q[0].addr || out_data !== q[0].data) begin
               n_err++; $display("FAIL wrap_head_c%0d got a=%0d d=%h exp a=%0d d=%h",
                                 cyc, out_addr, out_data, q[0].addr, q[0].data);
            end
         end
         n_vec++; if (drop !== exp_drop) begin
            n_err++; $display("FAIL wrap_drop_c%0d got=%b exp=%b", cyc, drop, exp_drop);
         end
         pop = (q.size() != 0) && out_ready;
         acc = memwrite && (q.size() < 8 || pop);
         exp_drop = memwrite && !acc;
         if (pop) void'(q.pop_front());
         if (acc) begin
            e.addr = addr; e.data = wdata;
            q.push_back(e);
         end
         if (memwrite) pushes++;
         step();
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 200) begin
         n_vec++; n_err++;
         $display("FAIL wrap_timeout got cycles=%0d exp <200", cyc);
      end
      memwrite = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         memwrite = 1'b1; addr = 32'(i); wdata = 32'(900 + i);
         step();
      end
      @(negedge clk);
      n_vec++; if (level !== 4'd5) begin n_err++; $display("FAIL rmid_pre got level=%0d exp=5", level); end
      reset = 1'b1; memwrite = 1'b1; addr = 32'd99; wdata = 32'd99;
      step();
      reset = 1'b0; memwrite = 1'b0;
      @(negedge clk);
      n_vec++; if (level !== 4'd0 || out_valid !== 1'b0 || drop !== 1'b0 || full !== 1'b0) begin
         n_err++; $display("FAIL rmid_post got level=%0d v=%b drop=%b full=%b exp 0 0 0 0",
                           level, out_valid, drop, full);
      end
      memwrite = 1'b1; addr = 32'd77; wdata = 32'h1234_ABCD;
      step();
      memwrite = 1'b0;
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_addr !== 32'd77 || out_data !== 32'h1234_ABCD || level !== 4'd1) begin
         n_err++; $display("FAIL rmid_first got v=%b a=%0d d=%h level=%0d exp v=1 a=77 d=1234abcd level=1",
                           out_valid, out_addr, out_data, level);
      end
      n_vec++; if (out_result !== 16'hABCD) begin
         n_err++; $display("FAIL rmid_result got=%h exp=abcd", out_result);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_drain got v=%b exp=0", out_valid); end
   endtask

`ifdef STORE_TRACE_DROPCNT_EN
   task automatic test_saturation();
      reset = 1'b1; step(); reset = 1'b0;
      out_ready = 1'b0; memwrite = 1'b1; addr = 32'd1; wdata = 32'd2;
      repeat (8 + 70000) step();
      @(negedge clk);
      n_vec++; if (drop_cnt !== 16'hFFFF || drop !== 1'b1) begin
         n_err++; $display("FAIL sat_reach got cnt=%h drop=%b exp cnt=ffff drop=1", drop_cnt, drop);
      end
      repeat (10) step();
      memwrite = 1'b0;
      step();
      @(negedge clk);
      n_vec++; if (drop_cnt !== 16'hFFFF || drop !== 1'b0) begin
         n_err++; $display("FAIL sat_hold got cnt=%h drop=%b exp cnt=ffff drop=0", drop_cnt, drop);
      end
   endtask
`endif

   initial begin
      #5_000_000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fibonacci();
      test_overflow();
      test_full_push_pop();
      test_wrap();
      test_reset_mid();
`ifdef STORE_TRACE_DROPCNT_EN
      test_saturation();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
